aes192_frame_loader: RTL
========================

AES192_FRAME_LOADER -- requirements
Module: aes192_frame_loader

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 0: the maximum idle cycles allowed between words inside a frame; 0 disables the timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_data, input, 32 bits: the frame word, most-significant word first.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 The block SHALL have port in_last, input, 1 bit: the sender marks the final word of the frame.
REQ-008 The block SHALL have port in_key, input, 1 bit, present only with AES_KEY_REUSE_EN: sampled on the first word of a frame; 1 means the frame carries a key.
REQ-009 The block SHALL have port key_out, output, 192 bits: the assembled cipher key for the downstream AES-192 encryptor.
REQ-010 The block SHALL have port blk_out, output, 128 bits: the assembled plaintext block for the encryptor.
REQ-011 The block SHALL have port out_valid, output, 1 bit: key_out and blk_out are a complete pair.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream consumes the pair.
REQ-013 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse when a frame is discarded.

Function
REQ-014 The block SHALL implement FSM states IDLE, LOAD_KEY, LOAD_DATA and PRESENT.
REQ-015 A word SHALL transfer only in a cycle where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be 1 in IDLE, LOAD_KEY and LOAD_DATA, and 0 in PRESENT.
REQ-017 A key frame SHALL be 10 words: 6 key words filling key[191:160] down to key[31:0], then 4 data words filling blk[127:96] down to blk[31:0].
REQ-018 A data-only frame SHALL be 4 words.
REQ-019 IDLE SHALL move on the first transfer to LOAD_KEY (key frame) or LOAD_DATA (data-only frame), storing that word in the first slot.
REQ-020 LOAD_KEY SHALL move to LOAD_DATA after the 6th key word.
REQ-021 LOAD_DATA SHALL move to PRESENT after the 4th data word, asserting out_valid on the next cycle.
REQ-022 Key words SHALL be staged in a shadow register and committed to key_out only when the frame completes, so a discarded frame leaves the previous key intact.
REQ-023 In PRESENT, key_out, blk_out and out_valid SHALL hold stable until out_valid and out_ready are both 1, then return to IDLE and clear out_valid on the next cycle.
REQ-024 in_last SHALL be 1 on the final word of a frame and 0 on every other word.
REQ-025 Any in_last mismatch SHALL pulse frame_err for one cycle, discard the frame and return to IDLE with no out_valid.
REQ-026 With TIMEOUT_CYC > 0, an inactivity counter SHALL clear on each transfer and increment each cycle in LOAD_KEY or LOAD_DATA without a transfer.
REQ-027 When the inactivity counter reaches TIMEOUT_CYC, the block SHALL pulse frame_err, discard the frame and go to IDLE.
REQ-028 The inactivity counter SHALL saturate and SHALL NOT run in IDLE or PRESENT.
REQ-029 When a frame error and a timeout occur in the same cycle, the block SHALL emit a single frame_err pulse.
REQ-030 Words SHALL be accepted back-to-back at one word per cycle, with no bubbles within a frame.

Reset
REQ-031 While rst_n is 0 at a clock edge, the next state SHALL be: FSM in IDLE, counters at 0, key_out and blk_out 0, out_valid 0, frame_err 0, key-loaded flag 0.
REQ-032 A reset asserted mid-frame or during PRESENT SHALL abandon the pair with no frame_err.
REQ-033 in_ready SHALL read 0 in any cycle where rst_n is 0.

Configuration
REQ-034 With AES_KEY_REUSE_EN defined, in_key SHALL exist and in_key=0 SHALL select a data-only frame that reuses the last committed key.
REQ-035 With AES_KEY_REUSE_EN defined, a data-only frame started while the key-loaded flag is 0 SHALL be consumed to its end and then produce frame_err with no out_valid.
REQ-036 Without AES_KEY_REUSE_EN, in_key SHALL be absent and every frame SHALL be a 10-word key frame.

Verification
REQ-037 The bench SHALL cover: key frame 00010203..14151617 then 00112233..ccddeeff, back-to-back with out_ready=1 -> out_valid on cycle 11; encryptor result dda97ca4864cdfe06eaf70a0ec0d7191.
REQ-038 The bench SHALL cover: out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable; the next frame is accepted only after the handshake.
REQ-039 The bench SHALL cover: in_last=1 on word 7 of a key frame -> one frame_err pulse, no out_valid, key_out unchanged.
REQ-040 The bench SHALL cover: TIMEOUT_CYC=3 with a stall of 3 cycles after word 2 -> frame_err on the 3rd stall cycle; a stall of 2 cycles completes normally.
REQ-041 The bench SHALL cover: with AES_KEY_REUSE_EN, a data-only frame after reset -> frame_err; after a key frame, data-only ffeeddcc.. -> out_valid with the previous key_out.
REQ-042 The bench SHALL cover: rst_n=0 for 1 cycle after word 8 -> all outputs 0, no frame_err; a fresh 10-word frame then works.

Source files
------------

// File: rtl/aes192_frame_loader.sv
// ---------------------------------------------------------------------------
// aes192_frame_loader
//
// Collects a word-serial frame (32-bit words, most-significant word first)
// into a 192-bit cipher key plus a 128-bit plaintext block and presents the
// pair to a downstream AES-192 encryptor with a valid/ready handshake.
//
//   key frame       : 6 key words, then 4 data words (10 words)
//   data-only frame : 4 data words, reusing the last committed key
//                     (only when AES_KEY_REUSE_EN is defined)
//
// Optional feature macro: AES_KEY_REUSE_EN
//   defined   -> in_key port exists; in_key=0 on the first word selects a
//                data-only frame.
//   undefined -> no in_key port; every frame is a 10-word key frame.
//
// Parameters
//   TIMEOUT_CYC : max idle cycles between words inside a frame (0 = off)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_data    in   [31:0] frame word
//   in_valid   in   in_data valid
//   in_ready   out  word accepted this cycle when in_valid is also 1
//   in_last    in   final word of the frame
//   in_key     in   (AES_KEY_REUSE_EN only) frame carries a key
//   key_out    out  [191:0] committed cipher key
//   blk_out    out  [127:0] plaintext block
//   out_valid  out  key_out/blk_out form a complete pair
//   out_ready  in   downstream consumes the pair
//   frame_err  out  one-cycle pulse when a frame is discarded
// ---------------------------------------------------------------------------
module aes192_frame_loader #(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
`ifdef AES_KEY_REUSE_EN
  input  logic         in_key,
`endif
  output logic [191:0] key_out,
  output logic [127:0] blk_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_err
);

  typedef enum logic [1:0] {IDLE, LOAD_KEY, LOAD_DATA, PRESENT} state_t;

  // Idle counter width; one spare bit of headroom is not needed because the
  // counter saturates at TIMEOUT_CYC.
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_t         r_state;
  logic [2:0]     r_wcnt;        // words taken in the current phase
  logic           r_is_key;      // current frame carries a key
  logic           r_key_loaded;  // a key has been committed since reset
  logic [191:0]   r_key_sh;      // key shadow, committed on frame completion
  logic [127:0]   r_blk_sh;      // block shadow
  logic [191:0]   r_key;
  logic [127:0]   r_blk;
  logic           r_ov;
  logic           r_err;
  logic           r_rdy;
  logic [TW-1:0]  r_idle;

  logic           w_xfer;
  logic           w_key_frame;
  logic           w_final;
  logic           w_last_bad;
  logic           w_loading;
  logic           w_timeout;

  assign w_xfer = in_valid & in_ready;

`ifdef AES_KEY_REUSE_EN
  assign w_key_frame = in_key;
`else
  assign w_key_frame = 1'b1;
`endif

  // The only word allowed to carry in_last is the 4th data word. Frames are
  // never a single word, so in IDLE and LOAD_KEY in_last is always wrong.
  assign w_final    = (r_state == LOAD_DATA) && (r_wcnt == 3'd3);
  assign w_last_bad = w_xfer && (in_last != w_final);

  assign w_loading  = (r_state == LOAD_KEY) || (r_state == LOAD_DATA);

  // Fires on the idle cycle that brings the count up to TIMEOUT_CYC. A
  // transfer and a timeout are mutually exclusive by construction, so a
  // last-flag error and a timeout can never produce two pulses.
  assign w_timeout  = (TIMEOUT_CYC > 0) && w_loading && !w_xfer &&
                      (r_idle == TW'(TIMEOUT_CYC - 1));

  // Inactivity counter: only runs mid-frame, clears on every transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (!w_loading || w_xfer) begin
      r_idle <= '0;
    end else if (r_idle != TW'(TIMEOUT_CYC)) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wcnt       <= '0;
      r_is_key     <= 1'b0;
      r_key_loaded <= 1'b0;
      r_key_sh     <= '0;
      r_blk_sh     <= '0;
      r_key        <= '0;
      r_blk        <= '0;
      r_ov         <= 1'b0;
      r_err        <= 1'b0;
      r_rdy        <= 1'b1;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_last_bad) begin
              r_err <= 1'b1;
            end else if (w_key_frame) begin
              r_is_key <= 1'b1;
              r_key_sh <= {r_key_sh[159:0], in_data};
              r_wcnt   <= 3'd1;
              r_state  <= LOAD_KEY;
            end else begin
              r_is_key <= 1'b0;
              r_blk_sh <= {r_blk_sh[95:0], in_data};
              r_wcnt   <= 3'd1;
              r_state  <= LOAD_DATA;
            end
          end
        end

        LOAD_KEY: begin
          if (w_xfer) begin
            if (w_last_bad) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else begin
              // Shifting in from the bottom puts word 0 at key[191:160]
              // once all six words are in.
              r_key_sh <= {r_key_sh[159:0], in_data};
              if (r_wcnt == 3'd5) begin
                r_wcnt  <= '0;
                r_state <= LOAD_DATA;
              end else begin
                r_wcnt <= r_wcnt + 3'd1;
              end
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end

        LOAD_DATA: begin
          if (w_xfer) begin
            if (w_last_bad) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else if (w_final) begin
              if (r_is_key || r_key_loaded) begin
                r_blk <= {r_blk_sh[95:0], in_data};
                if (r_is_key) begin
                  r_key        <= r_key_sh;
                  r_key_loaded <= 1'b1;
                end
                r_ov    <= 1'b1;
                r_rdy   <= 1'b0;
                r_state <= PRESENT;
              end else begin
                // Data-only frame with no key to reuse: consumed, dropped.
                r_err   <= 1'b1;
                r_state <= IDLE;
              end
            end else begin
              r_blk_sh <= {r_blk_sh[95:0], in_data};
              r_wcnt   <= r_wcnt + 3'd1;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end

        PRESENT: begin
          // out_valid is high throughout PRESENT, so out_ready alone
          // completes the handshake.
          if (out_ready) begin
            r_ov    <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Gate with rst_n so in_ready is low during every reset cycle, not only
  // after the first reset edge.
  assign in_ready  = rst_n & r_rdy;
  assign key_out   = r_key;
  assign blk_out   = r_blk;
  assign out_valid = r_ov;
  assign frame_err = r_err;

endmodule
